// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Optional RAM wait timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 15
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  s0_valid_i,
  input  logic                  s0_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] s0_addr_i,
  input  logic [WIDTH-1:0]      s0_wdata_i,
  output logic                  s0_ready_o,
  output logic [WIDTH-1:0]      s0_rdata_o,
  output logic                  s0_err_o,
  input  logic                  s1_valid_i,
  input  logic                  s1_wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] s1_addr_i,
  input  logic [WIDTH-1:0]      s1_wdata_i,
  output logic                  s1_ready_o,
  output logic [WIDTH-1:0]      s1_rdata_o,
  output logic                  s1_err_o,
  output logic                  m_valid_o,
  output logic                  m_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] m_addr_o,
  output logic [WIDTH-1:0]      m_wdata_o,
  input  logic                  m_ready_i,
  input  logic [WIDTH-1:0]      m_rdata_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;   // 1: S1 wins a tie
  logic                  m_valid_q, m_valid_d;
  logic                  m_wr_rd_q, m_wr_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [WIDTH-1:0]      m_wdata_q, m_wdata_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            ready_q, ready_d;
  logic [WIDTH-1:0]      s0_rdata_q, s0_rdata_d;
  logic [WIDTH-1:0]      s1_rdata_q, s1_rdata_d;
  logic                  win_s;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            err_q, err_d;
`endif

  // Next-state and output register computation
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    m_valid_d  = m_valid_q;
    m_wr_rd_d  = m_wr_rd_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    grant_d    = grant_q;
    ready_d    = ready_q;
    s0_rdata_d = s0_rdata_q;
    s1_rdata_d = s1_rdata_q;
    win_s      = s1_valid_i && (!s0_valid_i || prio_q);
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (s0_valid_i || s1_valid_i) begin
          state_d   = BUSY;
          prio_d    = !win_s;
          m_valid_d = 1'b1;
          m_wr_rd_d = win_s ? s1_wr_rd_i : s0_wr_rd_i;
          m_addr_d  = win_s ? s1_addr_i : s0_addr_i;
          m_wdata_d = win_s ? s1_wdata_i : s0_wdata_i;
          grant_d   = win_s ? 2'b10 : 2'b01;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d     = 8'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (m_ready_i) begin
          state_d    = RESP;
          m_valid_d  = 1'b0;
          ready_d    = grant_q;
          s0_rdata_d = (grant_q[0] && !m_wr_rd_q) ? m_rdata_i : {WIDTH{1'b0}};
          s1_rdata_d = (grant_q[1] && !m_wr_rd_q) ? m_rdata_i : {WIDTH{1'b0}};
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Counter reaching TIMEOUT on this edge means TIMEOUT BUSY cycles elapsed
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d    = RESP;
          m_valid_d  = 1'b0;
          ready_d    = grant_q;
          err_d      = grant_q;
          s0_rdata_d = {WIDTH{1'b0}};
          s1_rdata_d = {WIDTH{1'b0}};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        else begin
          state_d = BUSY;
        end
`endif
      end
      RESP: begin
        state_d    = IDLE;
        ready_d    = 2'b00;
        grant_d    = 2'b00;
        s0_rdata_d = {WIDTH{1'b0}};
        s1_rdata_d = {WIDTH{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
        err_d      = 2'b00;
`endif
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
        grant_d   = 2'b00;
        ready_d   = 2'b00;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      prio_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      m_wr_rd_q  <= 1'b0;
      m_addr_q   <= {ADDR_WIDTH{1'b0}};
      m_wdata_q  <= {WIDTH{1'b0}};
      grant_q    <= 2'b00;
      ready_q    <= 2'b00;
      s0_rdata_q <= {WIDTH{1'b0}};
      s1_rdata_q <= {WIDTH{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= 8'd0;
      err_q      <= 2'b00;
`endif
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      m_valid_q  <= m_valid_d;
      m_wr_rd_q  <= m_wr_rd_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      grant_q    <= grant_d;
      ready_q    <= ready_d;
      s0_rdata_q <= s0_rdata_d;
      s1_rdata_q <= s1_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign m_valid_o  = m_valid_q;
  assign m_wr_rd_o  = m_wr_rd_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;
  assign grant_o    = grant_q;
  assign s0_ready_o = ready_q[0];
  assign s1_ready_o = ready_q[1];
  assign s0_rdata_o = s0_rdata_q;
  assign s1_rdata_o = s1_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign s0_err_o   = err_q[0];
  assign s1_err_o   = err_q[1];
`else
  assign s0_err_o   = 1'b0;
  assign s1_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed, table-driven bench for mem_rr_arbiter with a behavioural RAM responder.
module tb_mem_rr_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        s0_valid_i, s0_wr_rd_i, s1_valid_i, s1_wr_rd_i;
  logic [3:0]  s0_addr_i, s1_addr_i, m_addr_o;
  logic [31:0] s0_wdata_i, s1_wdata_i, s0_rdata_o, s1_rdata_o, m_wdata_o, m_rdata_i;
  logic        s0_ready_o, s1_ready_o, s0_err_o, s1_err_o;
  logic        m_valid_o, m_wr_rd_o, m_ready_i;
  logic [1:0]  grant_o;

  logic [31:0] ram [16];
  logic [31:0] exp_mem [16];
  int          ram_lat;
  int          wait_cnt;
  int          n_total;
  int          n_pass;

  mem_rr_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_valid_i(s0_valid_i), .s0_wr_rd_i(s0_wr_rd_i), .s0_addr_i(s0_addr_i),
    .s0_wdata_i(s0_wdata_i), .s0_ready_o(s0_ready_o), .s0_rdata_o(s0_rdata_o), .s0_err_o(s0_err_o),
    .s1_valid_i(s1_valid_i), .s1_wr_rd_i(s1_wr_rd_i), .s1_addr_i(s1_addr_i),
    .s1_wdata_i(s1_wdata_i), .s1_ready_o(s1_ready_o), .s1_rdata_o(s1_rdata_o), .s1_err_o(s1_err_o),
    .m_valid_o(m_valid_o), .m_wr_rd_o(m_wr_rd_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .m_ready_i(m_ready_i), .m_rdata_i(m_rdata_i),
    .grant_o(grant_o)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: asserts ready after ram_lat cycles of valid, writes on the accepting edge
  always @(negedge clk_i) begin
    if (m_valid_o) begin
      if (wait_cnt >= ram_lat) begin
        m_ready_i = 1'b1;
      end else begin
        m_ready_i = 1'b0;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      m_ready_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  always @(posedge clk_i) begin
    if (m_valid_o && m_ready_i && m_wr_rd_o) ram[m_addr_o] <= m_wdata_o;
  end

  assign m_rdata_i = ram[m_addr_o];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive_port(input int port, input logic v, input logic wr,
                            input logic [3:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      s0_valid_i = v; s0_wr_rd_i = wr; s0_addr_i = addr; s0_wdata_i = wdata;
    end else begin
      s1_valid_i = v; s1_wr_rd_i = wr; s1_addr_i = addr; s1_wdata_i = wdata;
    end
  endtask

  // One complete transaction from an idle arbiter, checking grant, RAM side and response
  task automatic run_txn(input int port, input logic wr, input logic [3:0] addr,
                         input logic [31:0] wdata, input int lat, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_cycles);
    logic [1:0]  exp_grant;
    int          n;
    logic        done;
    logic        held;
    logic        other_rdy;
    logic        rdy;
    logic        err;
    logic [31:0] rdata;
    exp_grant = (port == 0) ? 2'b01 : 2'b10;
    @(negedge clk_i);
    ram_lat = lat;
    drive_port(port, 1'b1, wr, addr, wdata);
    @(posedge clk_i); #1;
    chk("grant", {30'd0, grant_o}, {30'd0, exp_grant});
    chk("m_valid", {31'd0, m_valid_o}, 32'd1);
    chk("m_addr", {28'd0, m_addr_o}, {28'd0, addr});
    chk("m_wr_rd", {31'd0, m_wr_rd_o}, {31'd0, wr});
    if (wr) chk("m_wdata", m_wdata_o, wdata);
    n = 0; done = 1'b0; held = 1'b1; other_rdy = 1'b0;
    rdy = 1'b0; err = 1'b0; rdata = 32'd0;
    while (!done && n < 200) begin
      @(posedge clk_i); #1;
      n = n + 1;
      rdy = (port == 0) ? s0_ready_o : s1_ready_o;
      if (((port == 0) ? s1_ready_o : s0_ready_o) == 1'b1) other_rdy = 1'b1;
      if (rdy) begin
        done  = 1'b1;
        err   = (port == 0) ? s0_err_o : s1_err_o;
        rdata = (port == 0) ? s0_rdata_o : s1_rdata_o;
      end else if (!m_valid_o) begin
        held = 1'b0;
      end
    end
    chk("ready_seen", {31'd0, done}, 32'd1);
    chk("latency", n, exp_cycles);
    chk("m_valid_held", {31'd0, held}, 32'd1);
    chk("other_ready", {31'd0, other_rdy}, 32'd0);
    chk("rdata", rdata, exp_rdata);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    drive_port(port, 1'b0, 1'b0, 4'd0, 32'd0);
    @(posedge clk_i); #1;
    chk("ready_pulse_end", {30'd0, s1_ready_o, s0_ready_o}, 32'd0);
    chk("grant_release", {30'd0, grant_o}, 32'd0);
  endtask

  typedef struct {
    int          port;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs [8];
  logic [1:0]  exp_seq [6];
  logic [1:0]  gseq [6];

  initial begin
    int         ng;
    logic [1:0] prev;
    logic       stop;
    logic [31:0] d;

    vecs[0] = '{0, 1'b1, 4'd3,  32'h1234_5678, 0, 32'h0000_0000};
    vecs[1] = '{1, 1'b0, 4'd3,  32'h0000_0000, 0, 32'h1234_5678};
    vecs[2] = '{1, 1'b1, 4'd5,  32'hDEAD_BEEF, 3, 32'h0000_0000};
    vecs[3] = '{0, 1'b0, 4'd5,  32'h0000_0000, 2, 32'hDEAD_BEEF};
    vecs[4] = '{0, 1'b0, 4'd7,  32'h0000_0000, 1, 32'h0000_0000};
    vecs[5] = '{1, 1'b1, 4'd3,  32'hA5A5_A5A5, 0, 32'h0000_0000};
    vecs[6] = '{0, 1'b0, 4'd3,  32'h0000_0000, 0, 32'hA5A5_A5A5};
    vecs[7] = '{1, 1'b0, 4'd15, 32'h0000_0000, 4, 32'h0000_0000};
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    n_total = 0; n_pass = 0; ram_lat = 0; wait_cnt = 0; m_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin ram[i] = 32'd0; exp_mem[i] = 32'd0; end
    drive_port(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive_port(1, 1'b0, 1'b0, 4'd0, 32'd0);

    // Reset state
    rst_ni = 1'b0;
    #1;
    chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_grant", {30'd0, grant_o}, 32'd0);
    chk("rst_ready", {30'd0, s1_ready_o, s0_ready_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;

    // Asynchronous reset in the middle of a stalled transaction
    @(negedge clk_i);
    ram_lat = 1000;
    drive_port(0, 1'b1, 1'b0, 4'd2, 32'd0);
    @(posedge clk_i); #1;
    chk("midrst_grant_before", {30'd0, grant_o}, 32'd1);
    repeat (3) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("midrst_grant", {30'd0, grant_o}, 32'd0);
    chk("midrst_ready", {30'd0, s1_ready_o, s0_ready_o}, 32'd0);
    drive_port(0, 1'b0, 1'b0, 4'd0, 32'd0);
    @(negedge clk_i) rst_ni = 1'b1;
    ram_lat = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("postrst_idle_grant", {30'd0, grant_o}, 32'd0);
    chk("postrst_idle_valid", {31'd0, m_valid_o}, 32'd0);

    // Both ports requesting continuously: grants must alternate starting with S0
    @(negedge clk_i);
    drive_port(0, 1'b1, 1'b0, 4'd0, 32'd0);
    drive_port(1, 1'b1, 1'b0, 4'd1, 32'd0);
    ng = 0; prev = 2'b00; stop = 1'b0;
    for (int c = 0; c < 100 && !stop; c++) begin
      @(posedge clk_i); #1;
      if (grant_o != 2'b00 && prev == 2'b00 && ng < 6) begin
        gseq[ng] = grant_o;
        ng = ng + 1;
      end
      prev = grant_o;
      if (ng == 6 && (s0_ready_o || s1_ready_o)) stop = 1'b1;
    end
    drive_port(0, 1'b0, 1'b0, 4'd0, 32'd0);
    drive_port(1, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("tie_grant_count", ng, 6);
    for (int i = 0; i < 6; i++) begin
      if (i < ng) chk($sformatf("tie_grant_%0d", i), {30'd0, gseq[i]}, {30'd0, exp_seq[i]});
      else chk($sformatf("tie_grant_%0d", i), 32'd0, {30'd0, exp_seq[i]});
    end
    repeat (2) @(posedge clk_i);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
              vecs[i].lat, vecs[i].exp_rdata, 1'b0, vecs[i].lat + 1);
      if (vecs[i].wr) exp_mem[vecs[i].addr] = vecs[i].wdata;
    end

    // Fill all addresses through alternating ports, then read back crosswise
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      exp_mem[i] = d;
      run_txn(i % 2, 1'b1, 4'(i), d, i % 3, 32'd0, 1'b0, (i % 3) + 1);
    end
    for (int i = 0; i < 16; i++) begin
      run_txn((i + 1) % 2, 1'b0, 4'(i), 32'd0, 0, exp_mem[i], 1'b0, 1);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // RAM never answers: error response after TIMEOUT BUSY cycles, then normal service
    run_txn(1, 1'b0, 4'd9, 32'd0, 1000, 32'd0, 1'b1, TIMEOUT);
    run_txn(0, 1'b0, 4'd9, 32'd0, 0, exp_mem[9], 1'b0, 1);
`else
    // Long RAM stall: the arbiter keeps waiting with m_valid_o held
    run_txn(1, 1'b0, 4'd9, 32'd0, 30, exp_mem[9], 1'b0, 31);
    run_txn(0, 1'b0, 4'd9, 32'd0, 0, exp_mem[9], 1'b0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
